mem_bus_bridge: RTL

- Sits between the multi-cycle RISC-V core's memory port (adr/writedata/memwrite/readdata) and a synchronous, handshaked memory or bus.
- Converts one single-beat core access into a valid/ready request phase plus a read-response phase.
- Stalls the core with c_stall until the access completes.
- Flags misaligned accesses and, optionally, bus timeouts.

---
 rtl/mem_bus_bridge_pkg.sv | 6 +
 rtl/mem_bus_bridge_timer.sv | 22 ++
 rtl/mem_bus_bridge.sv | 88 ++++++++
 3 files changed

// File: rtl/mem_bus_bridge_pkg.sv
// mem_bus_bridge_pkg: shared state encoding and constants for the core-to-bus bridge
package mem_bus_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAITR, DONE} state_t;
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [1:0]  ALIGN_MASK   = 2'b11;
endpackage

// File: rtl/mem_bus_bridge_timer.sv
// bridge_timer: cycle counter with synchronous clear, count enable and expiry flag
//   clk, reset : clock, asynchronous active-high reset
//   clr        : zero the count
//   en         : count this cycle
//   expire     : high in the enabled cycle that completes LIMIT counted cycles
module bridge_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expire = en && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns a single-beat core access into a valid/ready request plus read response
//   clk, reset          : clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata : core access request, write flag, byte address, write data
//   c_rdata             : registered read data, held until the next completed read
//   c_stall             : core must hold while high
//   c_err               : one-cycle error pulse with completion (misaligned or timeout)
//   m_valid/m_ready     : memory request handshake
//   m_we/m_addr/m_wdata : captured request, word-aligned address
//   m_rvalid/m_rdata    : read response, only honoured while waiting for it
//   Optional: MEM_BUS_BRIDGE_TIMEOUT_EN aborts after TIMEOUT_CYC ISSUE+WAITR cycles.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  output logic              c_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);
  state_t state, state_n;
  logic   err_q, timeout, misaligned;
  assign misaligned = (c_addr[1:0] & ALIGN_MASK) != 2'b00;
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  bridge_timer #(.W(TW), .LIMIT(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == IDLE),
    .en     (state == ISSUE || state == WAITR),
    .expire (timeout)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Timeout outranks a same-cycle handshake so an abort is never half-taken.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = c_req ? (misaligned ? DONE : ISSUE) : IDLE;
      ISSUE:   state_n = timeout ? DONE : m_ready ? (m_we ? DONE : WAITR) : ISSUE;
      WAITR:   state_n = (timeout || m_rvalid) ? DONE : WAITR;
      default: state_n = IDLE;
    endcase
    m_valid = state == ISSUE;
    c_stall = state == IDLE ? c_req : state != DONE;
    c_err   = state == DONE && err_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      c_rdata <= '0;
      err_q   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      if (state == IDLE && c_req) begin
        m_we    <= c_we;
        m_addr  <= c_addr & ~ADDR_W'(ALIGN_MASK);
        m_wdata <= c_wdata;
        err_q   <= misaligned;
      end
      if (state == DONE) err_q <= 1'b0;
      if (timeout) begin
        err_q <= 1'b1;
        if (!m_we) c_rdata <= DATA_W'(BUS_ERR_DATA);
      end else if (state == WAITR && m_rvalid) c_rdata <= m_rdata;
    end
endmodule
